bs_loader: RTL and testbench
============================

# bs_loader

Bitstream loader for the neurochip configuration chain. It accepts configuration bytes over a valid/ready interface and serialises them MSB-first onto the chain's serial input while asserting the chain's shift enable. At the same time it captures the bits falling out of the chain tail and returns them as readback bytes. It drives `config_en`/`bs_in` of the fabric and reads `bs_out` on the host-facing side.

## Interface

Parameters:
- `BS_LENGTH`, default 400: total bits in the configuration chain (≥ 1).
- `BYTES`, derived as ceil(`BS_LENGTH`/8): number of bytes per load.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Honoured only in IDLE.
- `in_data`  in  8  configuration byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `cfg_en`  out  1  chain shift enable, registered.
- `chain_in`  out  1  serial bit to the chain input, registered.
- `chain_tail`  in  1  current chain last bit (pre-shift value).
- `rb_data`  out  8  readback byte.
- `rb_valid`  out  1  one-cycle strobe for `rb_data`. No backpressure.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.

## Operation

- States:
  - IDLE: `start` → LOAD. Clears the bit counter and the readback collector.
  - LOAD: `in_ready`=1 while the output shifter is empty. A handshake moves to SHIFT.
  - SHIFT: one chain bit per cycle.
    - Once `BS_LENGTH` total bits have been shifted → DONE.
    - After 8 bits, if a new byte was accepted in the last shift cycle → stay in SHIFT; otherwise → LOAD.
  - DONE: `done`=1 for one cycle → IDLE.
- Bit order: each byte is sent bit7 first. The first bit of the load ends at the chain's far end.
- Final byte: when `BS_LENGTH` mod 8 = r ≠ 0, only bits 7..8-r of the last byte are shifted and the rest are discarded.
- Readback:
  - Each shift cycle samples `chain_tail` and packs it MSB-first.
  - `rb_valid` fires after every 8th shifted bit and after the final bit.
  - A partial final readback byte is left-aligned with zero padding.
  - A load therefore returns the chain's previous contents.
- Stalls: if no byte is available in LOAD, `cfg_en`=0 and the chain holds its state.
- `start` is ignored while `busy`. `in_valid` in IDLE/DONE is not accepted (`in_ready`=0).
- Bit counter width: $clog2(`BS_LENGTH`+1). It never exceeds `BS_LENGTH`, and `in_ready` is 0 once all `BYTES` bytes have been accepted.
- Reset values: all outputs 0. State is IDLE, counters are 0.
- Reset mid-load: `cfg_en`=0 on the next cycle. The chain keeps its partially shifted contents (no recovery). Any later load restarts from bit 0.

## Timing

- Handshake at cycle T: `cfg_en`=1 in cycles T+1..T+8, with `chain_in` = bits 7..0.
- `in_ready` is also high in cycle T+8, the last shift cycle. With back-to-back `in_valid` the shifting is continuous, so a full load takes `BS_LENGTH` contiguous `cfg_en` cycles.
- `chain_tail` is sampled in each cycle where `cfg_en`=1.
- `rb_valid` is asserted in the cycle after the byte's last shift cycle, e.g. T+9.
- `done` is asserted in the cycle after the final `cfg_en` cycle. `busy` is 1 from the cycle after `start` through the `done` cycle, and 0 after it.

## Structure

- Shared package `neurochip_pkg`:
  - `BS_LENGTH_DEFAULT` = 400.
  - State enum {IDLE, LOAD, SHIFT, DONE}.
  - Config handshake typedefs.
- Natural sub-module: `bs_byte_serdes`, a combined 8-bit PISO and SIPO with a bit counter and last-byte truncation. The top level holds the FSM and the global bit counter.

## Test plan

- Full load, `BS_LENGTH`=400, 50 bytes 0x00..0x31 with `in_valid` always high → exactly 400 contiguous `cfg_en` cycles, a behavioural chain model equals the sent stream, one `done`.
- Readback: load pattern 0xA5 ×50, then load 0x3C ×50 → second load returns 50 `rb_data` = 0xA5. The first load returns 0x00 ×50 after chain reset.
- Stalls: drop `in_valid` for 5 cycles between bytes 10 and 11 → `cfg_en`=0 for those cycles, chain model unchanged, final contents still correct.
- Partial byte, `BS_LENGTH`=20: bytes 0xFF, 0x00, 0xAB → 20 shifts, last 4 bits 1,0,1,0. `in_ready`=0 after the 3rd byte. The third `rb_data` has its low nibble at 0.
- Reset at bit 100 → `cfg_en`, `busy`, `rb_valid` = 0 on the next cycle. A new `start` and 50 bytes produce 400 shifts and correct contents.
- `start` pulsed mid-load, and `in_valid` held in IDLE → no restart, no byte accepted, and the shift count is unaffected.

Source files
------------

// File: rtl/neurochip_pkg.sv
// neurochip_pkg: types shared by the configuration-chain loader blocks.
package neurochip_pkg;

   localparam int BS_LENGTH_DEFAULT = 400;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} ld_state_e;

   typedef logic [7:0] cfg_byte_t;

   typedef struct packed {
      logic      valid;
      cfg_byte_t data;
   } cfg_req_t;

endpackage

// File: rtl/bs_byte_serdes.sv
// bs_byte_serdes: byte PISO toward the chain input and SIPO from the chain
// tail, sharing one in-byte bit counter; the final byte may be truncated.
module bs_byte_serdes
   import neurochip_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      clear,
   input  logic      load,
   input  cfg_byte_t load_data,
   input  logic      shift,
   input  logic      final_bit,
   input  logic      chain_tail,
   output logic      byte_end,
   output logic      chain_in,
   output cfg_byte_t rb_data,
   output logic      rb_valid
);

   cfg_byte_t  piso_q, piso_d;
   cfg_byte_t  sipo_q, sipo_d;
   cfg_byte_t  rb_data_q, rb_data_d;
   logic [2:0] cnt_q, cnt_d;
   logic       chain_in_q, chain_in_d;
   logic       rb_valid_q, rb_valid_d;

   always_comb begin
      piso_d     = piso_q;
      sipo_d     = sipo_q;
      rb_data_d  = rb_data_q;
      cnt_d      = cnt_q;
      chain_in_d = chain_in_q;
      rb_valid_d = 1'b0;
      byte_end   = shift && ((cnt_q == 3'd7) || final_bit);

      if (shift) begin
         sipo_d     = {sipo_q[6:0], chain_tail};
         cnt_d      = cnt_q + 3'd1;
         chain_in_d = piso_q[7];
         piso_d     = {piso_q[6:0], 1'b0};
         if (byte_end) begin
            // Left-align the bits collected so far; older bits fall off the top.
            rb_valid_d = 1'b1;
            rb_data_d  = sipo_d << (3'd7 - cnt_q);
            chain_in_d = 1'b0;
         end
      end

      if (load) begin
         piso_d     = {load_data[6:0], 1'b0};
         chain_in_d = load_data[7];
         cnt_d      = 3'd0;
      end

      if (clear) begin
         piso_d     = '0;
         sipo_d     = '0;
         cnt_d      = 3'd0;
         chain_in_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         piso_q     <= '0;
         sipo_q     <= '0;
         rb_data_q  <= '0;
         cnt_q      <= 3'd0;
         chain_in_q <= 1'b0;
         rb_valid_q <= 1'b0;
      end else begin
         piso_q     <= piso_d;
         sipo_q     <= sipo_d;
         rb_data_q  <= rb_data_d;
         cnt_q      <= cnt_d;
         chain_in_q <= chain_in_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign chain_in = chain_in_q;
   assign rb_data  = rb_data_q;
   assign rb_valid = rb_valid_q;

endmodule

// File: rtl/bs_loader.sv
// bs_loader: streams configuration bytes MSB-first into the neurochip chain
// while returning the bits that fall out of the chain tail as readback bytes.
module bs_loader
   import neurochip_pkg::*;
#(
   parameter int BS_LENGTH = BS_LENGTH_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cfg_en,
   output logic       chain_in,
   input  logic       chain_tail,
   output logic [7:0] rb_data,
   output logic       rb_valid,
   output logic       busy,
   output logic       done
);

   localparam int BYTES = (BS_LENGTH + 7) / 8;
   localparam int CW    = $clog2(BS_LENGTH + 1);
   localparam int BW    = $clog2(BYTES + 1);

   ld_state_e     state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] byte_cnt_q, byte_cnt_d;
   logic          cfg_en_q, cfg_en_d;

   cfg_req_t      req;
   logic          load;
   logic          clear;
   logic          byte_end;
   logic          final_bit;

   assign req       = {in_valid, in_data};
   assign final_bit = (bit_cnt_q == CW'(BS_LENGTH - 1));

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      cfg_en_d   = 1'b0;
      in_ready   = 1'b0;
      clear      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               clear      = 1'b1;
            end
         end
         LOAD: begin
            in_ready = (byte_cnt_q < BW'(BYTES));
            if (req.valid && in_ready) begin
               state_d  = SHIFT;
               cfg_en_d = 1'b1;
            end
         end
         SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            cfg_en_d  = 1'b1;
            if (byte_end) begin
               cfg_en_d = 1'b0;
               if (final_bit) begin
                  state_d = DONE;
               end else begin
                  // Accepting in the last shift cycle keeps the chain moving gap-free.
                  in_ready = (byte_cnt_q < BW'(BYTES));
                  if (req.valid && in_ready) begin
                     cfg_en_d = 1'b1;
                  end else begin
                     state_d = LOAD;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      load = req.valid && in_ready;
      if (load) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         cfg_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         cfg_en_q   <= cfg_en_d;
      end
   end

   bs_byte_serdes u_serdes (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .load_data  (req.data),
      .shift      (cfg_en_q),
      .final_bit  (final_bit),
      .chain_tail (chain_tail),
      .byte_end   (byte_end),
      .chain_in   (chain_in),
      .rb_data    (rb_data),
      .rb_valid   (rb_valid)
   );

   assign cfg_en = cfg_en_q;
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_bs_loader.sv
// tb_bs_loader: directed checks of two loaders (400-bit and 20-bit chains)
// against behavioural chain shift registers.
module tb_bs_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       in_ready_a, cfg_en_a, chain_in_a, chain_tail_a, rb_valid_a, busy_a, done_a;
   logic [7:0] rb_data_a;
   logic       in_ready_b, cfg_en_b, chain_in_b, chain_tail_b, rb_valid_b, busy_b, done_b;
   logic [7:0] rb_data_b;

   logic [399:0] chain_a = '0;
   logic [19:0]  chain_b = '0;

   int tests = 0;
   int failed = 0;

   logic [7:0] tx [50];
   logic [7:0] rb_exp [50];

   always #5 clk = ~clk;

   bs_loader dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_a), .cfg_en(cfg_en_a), .chain_in(chain_in_a), .chain_tail(chain_tail_a),
      .rb_data(rb_data_a), .rb_valid(rb_valid_a), .busy(busy_a), .done(done_a)
   );

   bs_loader #(.BS_LENGTH(20)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_b), .cfg_en(cfg_en_b), .chain_in(chain_in_b), .chain_tail(chain_tail_b),
      .rb_data(rb_data_b), .rb_valid(rb_valid_b), .busy(busy_b), .done(done_b)
   );

   // Fabric models: the tail is the pre-shift last bit.
   always @(posedge clk) if (cfg_en_a) chain_a <= {chain_a[398:0], chain_in_a};
   always @(posedge clk) if (cfg_en_b) chain_b <= {chain_b[18:0], chain_in_b};
   assign chain_tail_a = chain_a[399];
   assign chain_tail_b = chain_b[19];

   logic       sel = 1'b0;
   logic       mon_clr = 1'b0;
   logic       m_cfg, m_cin, m_rdy, m_rbv, m_done, m_busy;
   logic [7:0] m_rbd;
   assign m_cfg  = sel ? cfg_en_b   : cfg_en_a;
   assign m_cin  = sel ? chain_in_b : chain_in_a;
   assign m_rdy  = sel ? in_ready_b : in_ready_a;
   assign m_rbv  = sel ? rb_valid_b : rb_valid_a;
   assign m_rbd  = sel ? rb_data_b  : rb_data_a;
   assign m_done = sel ? done_b     : done_a;
   assign m_busy = sel ? busy_b     : busy_a;

   int cyc = 0, en_cnt = 0, first_en = -1, last_en = -1, hs_cnt = 0, done_cnt = 0, idle_rdy = 0;
   logic [7:0] rbq [$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         en_cnt   <= 0;
         first_en <= -1;
         last_en  <= -1;
         hs_cnt   <= 0;
         done_cnt <= 0;
         idle_rdy <= 0;
         rbq.delete();
      end else begin
         if (m_cfg) begin
            en_cnt  <= en_cnt + 1;
            last_en <= cyc;
            if (first_en < 0) first_en <= cyc;
         end
         if (in_valid && m_rdy) hs_cnt <= hs_cnt + 1;
         if (m_done) done_cnt <= done_cnt + 1;
         if (m_rbv) rbq.push_back(m_rbd);
         if (sel && in_ready_a) idle_rdy <= idle_rdy + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [399:0] pack_tx();
      logic [399:0] v = '0;
      for (int i = 0; i < 50; i++) v = {v[391:0], tx[i]};
      return v;
   endfunction

   task automatic do_load(input logic s, input int n, input int stall_at, input int restart_at);
      int t;
      logic [399:0] snap;
      sel = s;
      step();
      if (s) start_b = 1'b1; else start_a = 1'b1;
      mon_clr = 1'b1;
      step();
      start_a = 1'b0;
      start_b = 1'b0;
      mon_clr = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            in_valid = 1'b0;
            t = 0;
            while (m_rdy !== 1'b1 && t < 50) begin step(); t++; end
            step();
            snap = s ? {380'd0, chain_b} : chain_a;
            repeat (4) step();
            check("stall_hold", s ? {380'd0, chain_b} : chain_a, snap);
            check("stall_cfg_en", m_cfg, 1'b0);
         end
         in_data  = tx[i];
         in_valid = 1'b1;
         t = 0;
         while (m_rdy !== 1'b1 && t < 50) begin step(); t++; end
         check("ready_wait", m_rdy, 1'b1);
         step();
         if (i == 0) begin
            check("first_cfg_en", m_cfg, 1'b1);
            check("first_bit", m_cin, tx[0][7]);
            check("busy_in_load", m_busy, 1'b1);
         end
         if (i == restart_at) begin
            if (s) start_b = 1'b1; else start_a = 1'b1;
            step();
            start_a = 1'b0;
            start_b = 1'b0;
         end
      end
      // Keep offering data: nothing beyond the last byte may be taken.
      in_data = 8'hEE;
      t = 0;
      while (m_done !== 1'b1 && t < 500) begin step(); t++; end
      check("done_wait", m_done, 1'b1);
      in_valid = 1'b0;
      step();
      step();
      check("busy_after", m_busy, 1'b0);
   endtask

   task automatic check_counts(input int en_exp, input int hs_exp, input int gap_exp);
      check("shift_count", en_cnt, en_exp);
      check("handshakes", hs_cnt, hs_exp);
      check("gap_cycles", last_en - first_en + 1 - en_cnt, gap_exp);
      check("done_pulses", done_cnt, 1);
   endtask

   task automatic check_rb(input int n);
      check("rb_count", rbq.size(), n);
      for (int i = 0; i < n && i < rbq.size(); i++) check("rb_data", rbq[i], rb_exp[i]);
   endtask

   initial begin
      int t;
      repeat (3) step();
      check("rst_cfg_en", cfg_en_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_rb_valid", rb_valid_a, 1'b0);
      reset = 1'b0;
      step();
      check("idle_outputs", {in_ready_a, cfg_en_a, chain_in_a, rb_data_a, rb_valid_a, busy_a, done_a}, 14'd0);

      // Load 1: ramp into a cleared chain, read back zeros.
      for (int i = 0; i < 50; i++) begin tx[i] = 8'(i); rb_exp[i] = 8'h00; end
      do_load(1'b0, 50, -1, -1);
      check_counts(400, 50, 0);
      check("chain_ramp", chain_a, pack_tx());
      check_rb(50);

      // Load 2: 0xA5 with start pulsed mid-load; readback is the ramp.
      for (int i = 0; i < 50; i++) begin tx[i] = 8'hA5; rb_exp[i] = 8'(i); end
      do_load(1'b0, 50, -1, 20);
      check_counts(400, 50, 0);
      check("chain_a5", chain_a, pack_tx());
      check_rb(50);

      // Load 3: 0x3C with a 5-cycle stall between bytes 10 and 11.
      for (int i = 0; i < 50; i++) begin tx[i] = 8'h3C; rb_exp[i] = 8'hA5; end
      do_load(1'b0, 50, 10, -1);
      check_counts(400, 50, 5);
      check("chain_3c", chain_a, pack_tx());
      check_rb(50);

      // 20-bit chain: last byte truncated to its top nibble.
      tx[0] = 8'hFF; tx[1] = 8'h00; tx[2] = 8'hAB;
      rb_exp[0] = 8'h00; rb_exp[1] = 8'h00; rb_exp[2] = 8'h00;
      do_load(1'b1, 3, -1, -1);
      check_counts(20, 3, 0);
      check("chain_b", chain_b, 20'hFF00A);
      check_rb(3);
      check("idle_a_ready", idle_rdy, 0);
      rb_exp[0] = 8'hFF; rb_exp[1] = 8'h00; rb_exp[2] = 8'hA0;
      do_load(1'b1, 3, -1, -1);
      check_counts(20, 3, 0);
      check("chain_b_again", chain_b, 20'hFF00A);
      check_rb(3);
      check("idle_a_ready2", idle_rdy, 0);
      check("idle_a_busy", busy_a, 1'b0);
      for (int i = 0; i < 50; i++) tx[i] = 8'h3C;
      check("idle_a_chain", chain_a, pack_tx());

      // Reset once 100 bits have shifted, then a full reload.
      sel = 1'b0;
      step();
      start_a = 1'b1;
      mon_clr = 1'b1;
      step();
      start_a  = 1'b0;
      mon_clr  = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      t = 0;
      while (en_cnt < 100 && t < 300) begin step(); t++; end
      check("abort_reached", en_cnt >= 100, 1'b1);
      reset = 1'b1;
      step();
      check("abort_cfg_en", cfg_en_a, 1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_rb_valid", rb_valid_a, 1'b0);
      reset    = 1'b0;
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 50; i++) tx[i] = 8'(8'hC0 + i);
      do_load(1'b0, 50, -1, -1);
      check_counts(400, 50, 0);
      check("chain_reload", chain_a, pack_tx());

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
